// File: rtl/l2_ecc_pkg.sv
// Shared definitions for the L2 ECC error monitor.
//   - Register byte offsets of the monitor's 32-bit register port.
//   - ctrl_t      : CTRL register layout (IRQ_EN, THR_EN).
//   - last_info_t : LAST_INFO register layout (bank, uncorrectable flag, valid).
package l2_ecc_pkg;

  localparam logic [31:0] REG_CTRL      = 32'h00;
  localparam logic [31:0] REG_THRESH    = 32'h04;
  localparam logic [31:0] REG_UERR_STAT = 32'h08;
  localparam logic [31:0] REG_LAST_ADDR = 32'h0C;
  localparam logic [31:0] REG_LAST_INFO = 32'h10;
  localparam logic [31:0] REG_CNT_BASE  = 32'h20;

  typedef struct packed {
    logic thr_en;  // bit1
    logic irq_en;  // bit0
  } ctrl_t;

  typedef struct packed {
    logic        valid;  // bit31
    logic [21:0] rsvd1;  // bits30:9
    logic        uerr;   // bit8
    logic [3:0]  rsvd0;  // bits7:4
    logic [3:0]  bank;   // bits3:0
  } last_info_t;

endpackage

// File: rtl/l2_ecc_sat_cnt.sv
// Saturating event counter for one L2 bank.
//   clk_i, rst_i : clock, synchronous active-high reset (count -> 0)
//   clr_i        : clear request; combined with inc_i the result is 1
//   inc_i        : count one event, sticking at all-ones
//   cnt_o        : registered count
//   cnt_nxt_o    : count that will be registered at the next edge
module l2_ecc_sat_cnt
  import l2_ecc_pkg::*;
#(
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic [CntWidth-1:0] cnt_nxt_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

  // A clear coinciding with an event must not lose the event.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CntWidth'(1) : '0;
    end else if (inc_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/l2_ecc_err_monitor.sv
// Per-bank ECC error monitor for the L2 subsystem.
//   clk_i, rst_i            : L2 clock, synchronous active-high reset
//   bank_cerr_i/bank_uerr_i : per-bank 1-cycle correctable / uncorrectable pulses
//   bank_addr_i             : per-bank failing word address, valid with that bank's pulse
//   reg_req_i/we_i/addr_i/wdata_i : register request, accepted every cycle
//   reg_rvalid_o/rdata_o/error_o  : registered response, 1 cycle after the request
//   ecc_error_o             : level, any sticky UERR or (THR_EN and some CNT >= THRESH)
//   ecc_irq_o               : 1-cycle pulse on the rising edge of ecc_error_o when IRQ_EN
module l2_ecc_err_monitor
  import l2_ecc_pkg::*;
#(
  parameter int NumBanks     = 4,
  parameter int CntWidth     = 16,
  parameter int AddrWidth    = 20,
  parameter int RegAddrWidth = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumBanks-1:0]           bank_cerr_i,
  input  logic [NumBanks-1:0]           bank_uerr_i,
  input  logic [NumBanks*AddrWidth-1:0] bank_addr_i,
  input  logic                          reg_req_i,
  input  logic                          reg_we_i,
  input  logic [RegAddrWidth-1:0]       reg_addr_i,
  input  logic [31:0]                   reg_wdata_i,
  output logic                          reg_rvalid_o,
  output logic [31:0]                   reg_rdata_o,
  output logic                          reg_error_o,
  output logic                          ecc_error_o,
  output logic                          ecc_irq_o
);

  ctrl_t                ctrl_q, ctrl_d;
  logic [CntWidth-1:0]  thresh_q, thresh_d;
  logic [NumBanks-1:0]  uerr_stat_q, uerr_stat_d;
  logic [AddrWidth-1:0] last_addr_q, last_addr_d;
  last_info_t           last_info_q, last_info_d;
  logic [CntWidth-1:0]  cnt_q [NumBanks];
  logic [CntWidth-1:0]  cnt_d [NumBanks];
  logic                 ecc_error_q, ecc_error_d, ecc_irq_q, ecc_irq_d;

  logic [31:0]          addr32;
  logic                 hit_ctrl, hit_thresh, hit_uerr, hit_laddr, hit_linfo, mapped, wr_en;
  logic [NumBanks-1:0]  cnt_hit, cnt_clr, cerr_eff;
  logic [2*NumBanks-1:0] evt;
  int                   cap_idx, cap_bank;
  logic                 cap_uerr, thr_hit;

  logic                 rsp_vld_p1, rsp_err_p1, rsp_err_d;
  logic [31:0]          rsp_rdata_p1, rsp_rdata_d;

  logic                 unused_wdata;
  assign unused_wdata = ^reg_wdata_i;

  // Lowest set index of {cerr, uerr}: uncorrectable banks occupy the low half.
  function automatic int lowest_set(input logic [2*NumBanks-1:0] v);
    int idx;
    idx = 0;
    for (int i = 2*NumBanks-1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Exact-match decode: misaligned addresses never match, so they fall out as unmapped.
  always_comb begin
    addr32     = 32'(reg_addr_i);
    hit_ctrl   = (addr32 == REG_CTRL);
    hit_thresh = (addr32 == REG_THRESH);
    hit_uerr   = (addr32 == REG_UERR_STAT);
    hit_laddr  = (addr32 == REG_LAST_ADDR);
    hit_linfo  = (addr32 == REG_LAST_INFO);
    cnt_hit    = '0;
    for (int b = 0; b < NumBanks; b++) begin
      cnt_hit[b] = (addr32 == REG_CNT_BASE + 32'(4*b));
    end
    mapped = hit_ctrl | hit_thresh | hit_uerr | hit_laddr | hit_linfo | (|cnt_hit);
    wr_en  = reg_req_i & reg_we_i & mapped;
  end

  assign cnt_clr  = wr_en ? cnt_hit : '0;
  // An event flagged both ways on one bank is only uncorrectable.
  assign cerr_eff = bank_cerr_i & ~bank_uerr_i;

  for (genvar b = 0; b < NumBanks; b++) begin : g_cnt
    l2_ecc_sat_cnt #(.CntWidth(CntWidth)) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (cnt_clr[b]),
      .inc_i     (cerr_eff[b]),
      .cnt_o     (cnt_q[b]),
      .cnt_nxt_o (cnt_d[b])
    );
  end

  // Read data comes from current state, before any same-cycle update.
  always_comb begin
    rsp_rdata_d = '0;
    rsp_err_d   = reg_req_i & ~mapped;
    if (reg_req_i && !reg_we_i) begin
      if (hit_ctrl)   rsp_rdata_d[1:0]           = ctrl_q;
      if (hit_thresh) rsp_rdata_d[CntWidth-1:0]  = thresh_q;
      if (hit_uerr)   rsp_rdata_d[NumBanks-1:0]  = uerr_stat_q;
      if (hit_laddr)  rsp_rdata_d[AddrWidth-1:0] = last_addr_q;
      if (hit_linfo)  rsp_rdata_d                = last_info_q;
      for (int b = 0; b < NumBanks; b++) begin
        if (cnt_hit[b]) rsp_rdata_d[CntWidth-1:0] = cnt_q[b];
      end
    end
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    thresh_d    = thresh_q;
    uerr_stat_d = uerr_stat_q;
    last_addr_d = last_addr_q;
    last_info_d = last_info_q;
    if (wr_en && hit_ctrl)   ctrl_d   = ctrl_t'(reg_wdata_i[1:0]);
    if (wr_en && hit_thresh) thresh_d = reg_wdata_i[CntWidth-1:0];
    if (wr_en && hit_uerr)   uerr_stat_d = uerr_stat_q & ~reg_wdata_i[NumBanks-1:0];
    if (wr_en && hit_linfo)  last_info_d.valid = 1'b0;
    // Set wins over W1C.
    uerr_stat_d = uerr_stat_d | bank_uerr_i;

    // Capture wins over a same-cycle LAST_INFO clear.
    evt      = {cerr_eff, bank_uerr_i};
    cap_idx  = lowest_set(evt);
    cap_uerr = (cap_idx < NumBanks);
    cap_bank = cap_uerr ? cap_idx : cap_idx - NumBanks;
    if (|evt) begin
      last_addr_d       = bank_addr_i[cap_bank*AddrWidth +: AddrWidth];
      last_info_d       = '0;
      last_info_d.bank  = 4'(cap_bank);
      last_info_d.uerr  = cap_uerr;
      last_info_d.valid = 1'b1;
    end

    // Error is evaluated on next state so it follows its cause by one cycle.
    thr_hit = 1'b0;
    for (int b = 0; b < NumBanks; b++) begin
      if (cnt_d[b] >= thresh_d) thr_hit = 1'b1;
    end
    ecc_error_d = (|uerr_stat_d) | (ctrl_d.thr_en & thr_hit);
    ecc_irq_d   = ctrl_d.irq_en & ecc_error_d & ~ecc_error_q;
  end

  // Stage p1: registered state and register-port response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q       <= '0;
      thresh_q     <= '1;
      uerr_stat_q  <= '0;
      last_addr_q  <= '0;
      last_info_q  <= '0;
      ecc_error_q  <= 1'b0;
      ecc_irq_q    <= 1'b0;
      rsp_vld_p1   <= 1'b0;
      rsp_err_p1   <= 1'b0;
      rsp_rdata_p1 <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      thresh_q     <= thresh_d;
      uerr_stat_q  <= uerr_stat_d;
      last_addr_q  <= last_addr_d;
      last_info_q  <= last_info_d;
      ecc_error_q  <= ecc_error_d;
      ecc_irq_q    <= ecc_irq_d;
      rsp_vld_p1   <= reg_req_i;
      rsp_err_p1   <= rsp_err_d;
      rsp_rdata_p1 <= rsp_rdata_d;
    end
  end

  assign reg_rvalid_o = rsp_vld_p1;
  assign reg_error_o  = rsp_err_p1;
  assign reg_rdata_o  = rsp_rdata_p1;
  assign ecc_error_o  = ecc_error_q;
  assign ecc_irq_o    = ecc_irq_q;

endmodule
